// File: rtl/lcd_watch_pkg.sv
// lcd_watch_pkg
// Shared definitions for the watch time-set path.
//   state_t     : digit-entry FSM states (S_TENS, S_ONES)
//   DIGIT_MAX   : largest legal keypad digit
//   HOUR_MAX    : default upper limit for the hour field
//   MINSEC_MAX  : default upper limit for the minute/second fields
//   digit_ok()  : true when a keypad code is a legal decimal digit
package lcd_watch_pkg;

    typedef enum logic {
        S_TENS = 1'b0,
        S_ONES = 1'b1
    } state_t;

    localparam logic [3:0] DIGIT_MAX  = 4'd9;
    localparam int         HOUR_MAX   = 23;
    localparam int         MINSEC_MAX = 59;

    function automatic logic digit_ok(input logic [3:0] d);
        return (d <= DIGIT_MAX);
    endfunction

endpackage

// File: rtl/lcd_watch_bcd2bin.sv
// lcd_watch_bcd2bin
// Combinational two-digit BCD to binary converter.
//   tens : tens digit (0..9)
//   ones : ones digit (0..9)
//   bin  : tens*10 + ones (0..99)
module lcd_watch_bcd2bin
    import lcd_watch_pkg::*;
(
    input  logic [3:0] tens,
    input  logic [3:0] ones,
    output logic [6:0] bin
);

    logic [6:0] tens_ext;
    logic [6:0] ones_ext;

    assign tens_ext = {3'b000, tens};
    assign ones_ext = {3'b000, ones};

    // x10 as x8 + x2 keeps this a pair of shifts and adders; legal digits
    // top out at 99 so 7 bits never overflow.
    assign bin = (tens_ext << 3) + (tens_ext << 1) + ones_ext;

endmodule

// File: rtl/lcd_watch_merge.sv
// lcd_watch_merge
// Two-digit keypad entry for the time-set path: takes a tens digit then a
// ones digit, range-checks the result and emits it with a one-cycle strobe.
//   clk          : system clock, rising edge
//   rst          : asynchronous active-high reset
//   clr          : synchronous abort of the current entry
//   digit_valid  : single-cycle strobe qualifying digit
//   digit        : keypad digit, legal 0..9
//   number       : last accepted binary value, held between entries
//   number_valid : one-cycle pulse when number has just been updated
//   error        : one-cycle pulse on a rejected or timed-out entry
//   entry_a      : tens digit being entered (display echo)
//   entry_b      : ones digit of the last completed entry (display echo)
//   busy         : high while waiting for the ones digit
module lcd_watch_merge
    import lcd_watch_pkg::*;
#(
    parameter int MAX_VAL = MINSEC_MAX,
    parameter int TIMEOUT = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       digit_valid,
    input  logic [3:0] digit,
    output logic [6:0] number,
    output logic       number_valid,
    output logic       error,
    output logic [3:0] entry_a,
    output logic [3:0] entry_b,
    output logic       busy
);

    localparam int             CW      = $clog2(TIMEOUT);
    localparam logic [CW-1:0]  TO_LAST = CW'(TIMEOUT - 1);
    localparam logic [6:0]     LIMIT   = 7'(MAX_VAL);

    state_t        state;
    logic [CW-1:0] count;
    logic [6:0]    sum;

    lcd_watch_bcd2bin u_bcd2bin (
        .tens (entry_a),
        .ones (digit),
        .bin  (sum)
    );

    // Pulses default low each cycle so a single event never stretches.
    // A digit on the timeout cycle wins because the digit branch is
    // tested before the counter compare.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_TENS;
            count        <= '0;
            number       <= '0;
            number_valid <= 1'b0;
            error        <= 1'b0;
            entry_a      <= '0;
            entry_b      <= '0;
            busy         <= 1'b0;
        end else begin
            number_valid <= 1'b0;
            error        <= 1'b0;
            if (clr) begin
                state   <= S_TENS;
                entry_a <= '0;
                count   <= '0;
                busy    <= 1'b0;
            end else begin
                case (state)
                    S_TENS: begin
                        if (digit_valid) begin
                            if (digit_ok(digit)) begin
                                entry_a <= digit;
                                count   <= '0;
                                state   <= S_ONES;
                                busy    <= 1'b1;
                            end else begin
                                error <= 1'b1;
                            end
                        end
                    end
                    S_ONES: begin
                        if (digit_valid) begin
                            if (digit_ok(digit)) begin
                                if (sum <= LIMIT) begin
                                    number       <= sum;
                                    entry_b      <= digit;
                                    number_valid <= 1'b1;
                                end else begin
                                    error <= 1'b1;
                                end
                            end else begin
                                error   <= 1'b1;
                                entry_a <= '0;
                            end
                            state <= S_TENS;
                            busy  <= 1'b0;
                            count <= '0;
                        end else if (count == TO_LAST) begin
                            error   <= 1'b1;
                            state   <= S_TENS;
                            entry_a <= '0;
                            count   <= '0;
                            busy    <= 1'b0;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                    default: state <= S_TENS;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lcd_watch_merge.sv
// tb_lcd_watch_merge
// Self-checking bench for lcd_watch_merge. Two instances share the inputs:
// one limited to 59 (minutes/seconds) and one limited to 23 (hours), both
// with an 8-cycle timeout.
module tb_lcd_watch_merge;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr = 1'b0;
    logic       digit_valid = 1'b0;
    logic [3:0] digit = 4'd0;

    logic [6:0] m_number, h_number;
    logic       m_nv, h_nv, m_err, h_err;
    logic [3:0] m_a, h_a, m_b, h_b;
    logic       m_busy, h_busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    lcd_watch_merge #(.MAX_VAL(59), .TIMEOUT(8)) dut_min (
        .clk (clk), .rst (rst), .clr (clr),
        .digit_valid (digit_valid), .digit (digit),
        .number (m_number), .number_valid (m_nv), .error (m_err),
        .entry_a (m_a), .entry_b (m_b), .busy (m_busy)
    );

    lcd_watch_merge #(.MAX_VAL(23), .TIMEOUT(8)) dut_hr (
        .clk (clk), .rst (rst), .clr (clr),
        .digit_valid (digit_valid), .digit (digit),
        .number (h_number), .number_valid (h_nv), .error (h_err),
        .entry_a (h_a), .entry_b (h_b), .busy (h_busy)
    );

    typedef struct {
        logic       clr;
        logic       dv;
        logic [3:0] digit;
        int         m_num;
        logic       m_nv;
        logic       m_err;
        int         h_num;
        logic       h_nv;
        logic       h_err;
        int         a;
        int         b_m;
        int         b_h;
        logic       busy;
    } vec_t;

    vec_t vecs[$];

    // Drive inputs at the falling edge, then sample 1 time unit after the
    // rising edge that consumes them.
    task automatic applyStimulus(input logic c, input logic v, input logic [3:0] d);
        @(negedge clk);
        clr         = c;
        digit_valid = v;
        digit       = d;
        @(posedge clk);
        #1;
        clr         = 1'b0;
        digit_valid = 1'b0;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic checkBoth(input string tag, input int mn, input logic mnv, input logic merr,
                             input int hn, input logic hnv, input logic herr,
                             input int a, input int bm, input int bh, input logic bsy);
        checkOutput({tag, " m_number"}, int'(m_number), mn);
        checkOutput({tag, " m_valid"},  int'(m_nv),     int'(mnv));
        checkOutput({tag, " m_error"},  int'(m_err),    int'(merr));
        checkOutput({tag, " m_entry_a"}, int'(m_a),     a);
        checkOutput({tag, " m_entry_b"}, int'(m_b),     bm);
        checkOutput({tag, " m_busy"},   int'(m_busy),   int'(bsy));
        checkOutput({tag, " h_number"}, int'(h_number), hn);
        checkOutput({tag, " h_valid"},  int'(h_nv),     int'(hnv));
        checkOutput({tag, " h_error"},  int'(h_err),    int'(herr));
        checkOutput({tag, " h_entry_a"}, int'(h_a),     a);
        checkOutput({tag, " h_entry_b"}, int'(h_b),     bh);
        checkOutput({tag, " h_busy"},   int'(h_busy),   int'(bsy));
    endtask

    initial begin
        // clr dv dig | m_num nv err | h_num nv err | a b_m b_h busy
        vecs.push_back('{0,0, 0,   0,0,0,   0,0,0,  0,0,0,0}); // idle after reset
        vecs.push_back('{0,1, 4,   0,0,0,   0,0,0,  4,0,0,1}); // tens 4
        vecs.push_back('{0,1, 7,  47,1,0,   0,0,1,  4,7,0,0}); // 47: ok / >23
        vecs.push_back('{0,0, 0,  47,0,0,   0,0,0,  4,7,0,0}); // pulses drop
        vecs.push_back('{0,1, 2,  47,0,0,   0,0,0,  2,7,0,1}); // tens 2
        vecs.push_back('{0,1, 5,  25,1,0,   0,0,1,  2,5,0,0}); // 25: ok / >23
        vecs.push_back('{0,1, 2,  25,0,0,   0,0,0,  2,5,0,1}); // tens 2
        vecs.push_back('{0,1, 3,  23,1,0,  23,1,0,  2,3,3,0}); // 23 both
        vecs.push_back('{0,1,12,  23,0,1,  23,0,1,  2,3,3,0}); // bad tens
        vecs.push_back('{0,1, 1,  23,0,0,  23,0,0,  1,3,3,1}); // tens 1
        vecs.push_back('{0,1,15,  23,0,1,  23,0,1,  0,3,3,0}); // bad ones
        vecs.push_back('{0,1, 0,  23,0,0,  23,0,0,  0,3,3,1}); // tens 0
        vecs.push_back('{1,1, 9,  23,0,0,  23,0,0,  0,3,3,0}); // clr drops digit
        vecs.push_back('{0,1, 0,  23,0,0,  23,0,0,  0,3,3,1}); // tens 0
        vecs.push_back('{0,1, 9,   9,1,0,   9,1,0,  0,9,9,0}); // 09
        vecs.push_back('{0,0, 0,   9,0,0,   9,0,0,  0,9,9,0}); // idle

        #1;
        checkBoth("reset", 0,0,0, 0,0,0, 0,0,0, 0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].clr, vecs[i].dv, vecs[i].digit);
            checkBoth($sformatf("vec%0d", i),
                      vecs[i].m_num, vecs[i].m_nv, vecs[i].m_err,
                      vecs[i].h_num, vecs[i].h_nv, vecs[i].h_err,
                      vecs[i].a, vecs[i].b_m, vecs[i].b_h, vecs[i].busy);
        end

        // Timeout: tens 3 at edge N, error visible after edge N+8.
        applyStimulus(0, 1, 4'd3);
        checkOutput("to_start busy", int'(m_busy), 1);
        for (int k = 1; k <= 8; k++) begin
            applyStimulus(0, 0, 4'd0);
            checkOutput($sformatf("to%0d m_error", k), int'(m_err),  (k == 8) ? 1 : 0);
            checkOutput($sformatf("to%0d h_error", k), int'(h_err),  (k == 8) ? 1 : 0);
            checkOutput($sformatf("to%0d busy", k),    int'(m_busy), (k == 8) ? 0 : 1);
        end
        checkOutput("to entry_a", int'(m_a), 0);
        checkOutput("to number", int'(m_number), 9);
        applyStimulus(0, 0, 4'd0);
        checkOutput("to_after error", int'(m_err), 0);

        // Ones digit arriving exactly on the timeout cycle is accepted.
        applyStimulus(0, 1, 4'd3);
        for (int k = 1; k <= 7; k++) applyStimulus(0, 0, 4'd0);
        checkOutput("edge pre busy", int'(m_busy), 1);
        applyStimulus(0, 1, 4'd5);
        checkBoth("edge35", 35,1,0, 9,0,1, 3,5,9, 0);
        applyStimulus(0, 0, 4'd0);
        checkOutput("edge35 valid low", int'(m_nv), 0);
        checkOutput("edge35 error low", int'(m_err), 0);

        // Asynchronous reset mid-entry discards the partial digit.
        applyStimulus(0, 1, 4'd5);
        checkOutput("rst pre busy", int'(m_busy), 1);
        rst = 1'b1;
        #2;
        checkBoth("rst_async", 0,0,0, 0,0,0, 0,0,0, 0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(0, 0, 4'd0);
        checkBoth("rst_idle", 0,0,0, 0,0,0, 0,0,0, 0);
        applyStimulus(0, 1, 4'd5);
        applyStimulus(0, 1, 4'd9);
        checkBoth("num59", 59,1,0, 0,0,1, 5,9,0, 0);
        applyStimulus(0, 0, 4'd0);
        checkBoth("num59_after", 59,0,0, 0,0,0, 5,9,0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lcd_watch_merge.md
# lcd_watch_merge

Sequential two-digit entry block for the watch's time-set path. It performs the inverse of the display digit split. It accepts a tens digit and then a ones digit from the keypad decoder, checks each digit and the combined value, and produces a single binary value (0..MAX_VAL) with a one-cycle valid strobe. The output feeds the hour, minute and second counter load ports. The entered digits are echoed so the LCD can show partial entry.

## Interface
- MAX_VAL, 59: largest legal combined value. Use 23 for hours and 59 for min/sec. Must be ≤ 99.
- TIMEOUT, 1000: number of CLK cycles allowed between the tens digit and the ones digit before entry is aborted. Must be ≥ 2.
- CLK  input  1  system clock, rising edge.
- RST  input  1  reset, asynchronous, active-high.
- CLR  input  1  synchronous abort of the current entry.
- DIGIT_VALID  input  1  DIGIT is presented this cycle. Single-cycle strobe; no backpressure.
- DIGIT  input  4  keypad digit. Legal range is 0..9.
- NUMBER  output  7  last accepted binary value. Held between entries.
- NUMBER_VALID  output  1  one-cycle pulse when NUMBER has just been updated.
- ERROR  output  1  one-cycle pulse on a rejected entry.
- ENTRY_A  output  4  tens digit currently being entered, for display echo.
- ENTRY_B  output  4  ones digit of the last completed entry, for display echo.
- BUSY  output  1  high while waiting for the ones digit.

## Operation
- All outputs are registered. Reset values:
  - NUMBER = 0, ENTRY_A = 0, ENTRY_B = 0.
  - NUMBER_VALID = 0, ERROR = 0, BUSY = 0.
  - FSM = S_TENS, timeout counter = 0.
- The FSM has two states, S_TENS and S_ONES.
- S_TENS:
  - DIGIT_VALID with DIGIT ≤ 9: ENTRY_A ← DIGIT, counter ← 0, go to S_ONES, BUSY ← 1.
  - DIGIT_VALID with DIGIT > 9: ERROR pulse; stay in S_TENS; ENTRY_A is unchanged.
- S_ONES:
  - DIGIT_VALID with DIGIT ≤ 9: compute SUM = ENTRY_A×10 + DIGIT, 7 bits, maximum 99.
    - If SUM ≤ MAX_VAL: NUMBER ← SUM, ENTRY_B ← DIGIT, NUMBER_VALID pulse.
    - Otherwise: ERROR pulse; NUMBER and ENTRY_B are unchanged.
    - In both cases go to S_TENS with BUSY ← 0.
  - DIGIT_VALID with DIGIT > 9: ERROR pulse, go to S_TENS, ENTRY_A ← 0.
  - No DIGIT_VALID: the counter increments. When the counter equals TIMEOUT−1, raise an ERROR pulse, go to S_TENS, set ENTRY_A ← 0 and reset the counter to 0.
- CLR in any state forces S_TENS, ENTRY_A ← 0, counter ← 0, BUSY ← 0. It produces no ERROR and no NUMBER_VALID.
- Priority: RST > CLR > DIGIT_VALID > timeout.
  - A digit arriving on the timeout cycle is accepted normally.
  - CLR together with DIGIT_VALID drops the digit.
- NUMBER_VALID and ERROR are mutually exclusive and never high for two consecutive cycles from a single event.
- Arithmetic: ×10 is implemented as (A<<3)+(A<<1), zero-extended to 7 bits. No overflow is possible because 9×10+9 = 99 < 128.

## Timing
- Tens digit accepted at edge N: BUSY is high and ENTRY_A is valid from N+1.
- Ones digit accepted at edge M: NUMBER, ENTRY_B and NUMBER_VALID are valid in cycle M+1. NUMBER_VALID is low again at M+2.
- Latency from the ones-digit strobe to the result is 1 cycle. Back-to-back entries are possible: a new tens digit may arrive at M+1.
- Timeout: tens digit at edge N with no further digit gives an ERROR pulse in the cycle after edge N+TIMEOUT, with BUSY low from that point.
- RST asserted mid-entry clears the state asynchronously. The partial digit is discarded and no pulse is emitted.

## Structure
- Shared package lcd_watch_pkg holds:
  - the state encoding (S_TENS, S_ONES);
  - DIGIT_MAX = 9;
  - default limits HOUR_MAX = 23 and MINSEC_MAX = 59.
- One combinational sub-module, lcd_watch_bcd2bin: inputs 4-bit tens and 4-bit ones, output 7-bit binary. It is reusable elsewhere in the time-set path.
- The top module holds the FSM, the timeout counter sized $clog2(TIMEOUT), the range compare and the output registers.

## Test plan
- MAX_VAL=59: digits 4 then 7 → NUMBER=47, one NUMBER_VALID pulse, ENTRY_A=4, ENTRY_B=7, BUSY low afterwards.
- MAX_VAL=23: digits 2 then 5 → ERROR pulse, NUMBER keeps its prior value (0 after reset), no NUMBER_VALID. Then 2, 3 → NUMBER=23.
- Invalid digit: DIGIT=12 in S_TENS → ERROR, state S_TENS. Then 1, then DIGIT=15 → ERROR, ENTRY_A=0, NUMBER unchanged.
- Timeout with TIMEOUT=8: digit 3, then 8 idle cycles → ERROR in the expected cycle, BUSY low. Repeat with digit 5 arriving exactly on the timeout cycle → NUMBER=35, no ERROR.
- CLR with DIGIT_VALID in S_ONES → digit dropped, no pulses, BUSY low. Next entry 0, 9 → NUMBER=9.
- RST pulse mid-entry after the tens digit 5 → all outputs return to reset values. Then entry 5, 9 → NUMBER=59.
